// File: rtl/matrix_pkg.sv
// Shared constants, address-field helpers and FSM state type for the matrix bus responder.
// Used by both the top level and the write synchronizer (MATRIX_WE_SYNC_EN selects its variant).
package matrix_pkg;

    localparam int ADDR_W = 13;

    // Address map regions carried in address[12:10]
    localparam logic [2:0] REG_CFG  = 3'd0;
    localparam logic [2:0] REG_A    = 3'd1;
    localparam logic [2:0] REG_B    = 3'd2;
    localparam logic [2:0] REG_C    = 3'd3;
    localparam logic [2:0] REG_STAT = 3'd4;

    localparam int STAT_DONE    = 0;
    localparam int STAT_BUSY    = 1;
    localparam int STAT_ERR_CFG = 2;
    localparam int STAT_ERR_WP  = 3;

    localparam int CFG_START_BIT = 31;
    localparam int CFG_ROWS_LSB  = 0;
    localparam int CFG_INNER_LSB = 8;
    localparam int CFG_COLS_LSB  = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [2:0] addr_region(input logic [ADDR_W-1:0] addr);
        return addr[12:10];
    endfunction

    function automatic logic [4:0] addr_row(input logic [ADDR_W-1:0] addr);
        return addr[9:5];
    endfunction

    function automatic logic [4:0] addr_col(input logic [ADDR_W-1:0] addr);
        return addr[4:0];
    endfunction

endpackage

// File: rtl/matrix_we_sync.sv
// Host write strobe conditioning: optional two-flop synchronizer, then a rising-edge detector.
// MATRIX_WE_SYNC_EN defined: we/address/data are synchronized; undefined: bus is synchronous.
module matrix_we_sync
    import matrix_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    output logic              commit,
    output logic [ADDR_W-1:0] commit_addr,
    output logic [DATA_W-1:0] commit_data
);

    // commit is a single-cycle qualifier; the top takes the write on the clock edge ending that cycle.
`ifdef MATRIX_WE_SYNC_EN
    logic [1:0]        we_sync;
    logic              we_prev;
    logic [ADDR_W-1:0] addr_s1, addr_s2;
    logic [DATA_W-1:0] data_s1, data_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_sync <= '0;
            we_prev <= 1'b0;
            addr_s1 <= '0;
            addr_s2 <= '0;
            data_s1 <= '0;
            data_s2 <= '0;
        end else begin
            we_sync <= {we_sync[0], we};
            we_prev <= we_sync[1];
            addr_s1 <= address;
            addr_s2 <= addr_s1;
            data_s1 <= data;
            data_s2 <= data_s1;
        end
    end

    assign commit      = we_sync[1] & ~we_prev;
    assign commit_addr = addr_s2;
    assign commit_data = data_s2;
`else
    logic we_s;
    logic we_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_s    <= 1'b0;
            we_prev <= 1'b0;
        end else begin
            we_s    <= we;
            we_prev <= we_s;
        end
    end

    assign commit      = we_s & ~we_prev;
    assign commit_addr = address;
    assign commit_data = data;
`endif

endmodule

// File: rtl/matrix_bus_responder.sv
// Host-bus responder for the matrix-multiply engine: operand stores, config/start, C capture, readback.
// Build option MATRIX_WE_SYNC_EN routes the host bus through a two-flop synchronizer.
module matrix_bus_responder
    import matrix_pkg::*;
#(
    parameter int SIZE_ROW_MAX    = 3,
    parameter int SIZE_COLUMN_MAX = 3,
    parameter int DATA_W          = 32
) (
    input  logic                                           CLOCK_25,
    input  logic                                           i_rst_n,
    input  logic [DATA_W-1:0]                              data,
    input  logic [ADDR_W-1:0]                              address,
    input  logic                                           we,
    output logic [DATA_W-1:0]                              o_data_rdt,
    output logic                                           o_start,
    output logic [7:0]                                     o_rows,
    output logic [7:0]                                     o_inner,
    output logic [7:0]                                     o_cols,
    output logic [SIZE_ROW_MAX*SIZE_COLUMN_MAX*DATA_W-1:0] o_a_mat,
    output logic [SIZE_ROW_MAX*SIZE_COLUMN_MAX*DATA_W-1:0] o_b_mat,
    input  logic                                           i_c_we,
    input  logic [4:0]                                     i_c_row,
    input  logic [4:0]                                     i_c_col,
    input  logic [DATA_W-1:0]                              i_c_data,
    input  logic                                           i_done,
    output state_t                                         dbg_state
);

    localparam int NUM   = SIZE_ROW_MAX * SIZE_COLUMN_MAX;
    localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;

    function automatic logic in_bounds(input logic [4:0] row, input logic [4:0] col);
        return (int'(row) < SIZE_ROW_MAX) && (int'(col) < SIZE_COLUMN_MAX);
    endfunction

    function automatic logic [IDX_W-1:0] elem_idx(input logic [4:0] row, input logic [4:0] col);
        return IDX_W'(int'(row) * SIZE_COLUMN_MAX + int'(col));
    endfunction

    logic              commit;
    logic [ADDR_W-1:0] commit_addr;
    logic [DATA_W-1:0] commit_data;

    matrix_we_sync #(
        .DATA_W(DATA_W)
    ) u_we_sync (
        .clk        (CLOCK_25),
        .rst_n      (i_rst_n),
        .we         (we),
        .address    (address),
        .data       (data),
        .commit     (commit),
        .commit_addr(commit_addr),
        .commit_data(commit_data)
    );

    state_t            state_q, state_d;
    logic              start_q;
    logic [7:0]        rows_q, inner_q, cols_q;
    logic              done_q, err_cfg_q, err_wp_q;
    logic [DATA_W-1:0] a_q [NUM];
    logic [DATA_W-1:0] b_q [NUM];
    logic [DATA_W-1:0] c_q [NUM];

    logic [2:0]        wr_region;
    logic [4:0]        wr_row, wr_col;
    logic [7:0]        cfg_rows, cfg_inner, cfg_cols;
    logic              sizes_ok;
    logic              idle_eff, cfg_commit, start_req, ab_commit;
    logic              start_accept, start_reject, a_write, b_write, wp_error;

    assign wr_region = addr_region(commit_addr);
    assign wr_row    = addr_row(commit_addr);
    assign wr_col    = addr_col(commit_addr);
    assign cfg_rows  = commit_data[CFG_ROWS_LSB  +: 8];
    assign cfg_inner = commit_data[CFG_INNER_LSB +: 8];
    assign cfg_cols  = commit_data[CFG_COLS_LSB  +: 8];

    // inner is both A's column count and B's row count, so it must fit both limits
    assign sizes_ok = (cfg_rows != 8'd0) && (cfg_inner != 8'd0) && (cfg_cols != 8'd0)
                   && (int'(cfg_rows)  <= SIZE_ROW_MAX)
                   && (int'(cfg_inner) <= SIZE_COLUMN_MAX)
                   && (int'(cfg_inner) <= SIZE_ROW_MAX)
                   && (int'(cfg_cols)  <= SIZE_COLUMN_MAX);

    always_ff @(posedge CLOCK_25 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // i_done is folded in before the commit is judged, so a same-cycle start sees IDLE
    always_comb begin
        state_d      = state_q;
        idle_eff     = 1'b0;
        start_accept = 1'b0;
        start_reject = 1'b0;
        a_write      = 1'b0;
        b_write      = 1'b0;
        wp_error     = 1'b0;
        cfg_commit   = commit && (wr_region == REG_CFG);
        start_req    = cfg_commit && commit_data[CFG_START_BIT] && !start_q;
        ab_commit    = commit && ((wr_region == REG_A) || (wr_region == REG_B));

        case (state_q)
            IDLE: idle_eff = 1'b1;
            BUSY: begin
                if (i_done) begin
                    idle_eff = 1'b1;
                    state_d  = IDLE;
                end
            end
        endcase

        if (start_req && idle_eff) begin
            if (sizes_ok) begin
                start_accept = 1'b1;
                state_d      = BUSY;
            end else begin
                start_reject = 1'b1;
            end
        end

        if (ab_commit) begin
            if (!idle_eff) begin
                wp_error = 1'b1;
            end else if (in_bounds(wr_row, wr_col)) begin
                a_write = (wr_region == REG_A);
                b_write = (wr_region == REG_B);
            end
        end
    end

    always_ff @(posedge CLOCK_25 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            start_q   <= 1'b0;
            rows_q    <= '0;
            inner_q   <= '0;
            cols_q    <= '0;
            done_q    <= 1'b0;
            err_cfg_q <= 1'b0;
            err_wp_q  <= 1'b0;
            o_start   <= 1'b0;
        end else begin
            o_start <= start_accept;
            if (cfg_commit) begin
                start_q <= commit_data[CFG_START_BIT];
                if (idle_eff) begin
                    rows_q  <= cfg_rows;
                    inner_q <= cfg_inner;
                    cols_q  <= cfg_cols;
                end
            end
            if (start_accept) begin
                done_q    <= 1'b0;
                err_cfg_q <= 1'b0;
                err_wp_q  <= 1'b0;
            end else begin
                if ((state_q == BUSY) && i_done) done_q    <= 1'b1;
                if (start_reject)                err_cfg_q <= 1'b1;
                if (wp_error)                    err_wp_q  <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_25 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            if (a_write) a_q[elem_idx(wr_row, wr_col)] <= commit_data;
            if (b_write) b_q[elem_idx(wr_row, wr_col)] <= commit_data;
        end
    end

    // Results land in any state; a new run starts from an all-zero C
    always_ff @(posedge CLOCK_25 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM; i++) c_q[i] <= '0;
        end else if (start_accept) begin
            for (int i = 0; i < NUM; i++) c_q[i] <= '0;
        end else if (i_c_we && in_bounds(i_c_row, i_c_col)) begin
            c_q[elem_idx(i_c_row, i_c_col)] <= i_c_data;
        end
    end

    logic [2:0]        rd_region;
    logic [4:0]        rd_row, rd_col;
    logic [DATA_W-1:0] status_word, rd_word;

    assign rd_region = addr_region(address);
    assign rd_row    = addr_row(address);
    assign rd_col    = addr_col(address);

    always_comb begin
        status_word               = '0;
        status_word[STAT_DONE]    = done_q;
        status_word[STAT_BUSY]    = (state_q == BUSY);
        status_word[STAT_ERR_CFG] = err_cfg_q;
        status_word[STAT_ERR_WP]  = err_wp_q;
    end

    always_comb begin
        rd_word = '0;
        case (rd_region)
            REG_C: begin
                if (in_bounds(rd_row, rd_col)) rd_word = c_q[elem_idx(rd_row, rd_col)];
            end
            REG_STAT: rd_word = status_word;
            default:  rd_word = '0;
        endcase
    end

    always_ff @(posedge CLOCK_25 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data_rdt <= '0;
        end else begin
            o_data_rdt <= rd_word;
        end
    end

    for (genvar i = 0; i < NUM; i++) begin : g_flat
        assign o_a_mat[i*DATA_W +: DATA_W] = a_q[i];
        assign o_b_mat[i*DATA_W +: DATA_W] = b_q[i];
    end

    assign o_rows    = rows_q;
    assign o_inner   = inner_q;
    assign o_cols    = cols_q;
    assign dbg_state = state_q;

endmodule
